// File: rtl/lb_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : lb_pkg
//  Purpose   : Shared word format for the line-buffer datapath. One pixel is
//              two packed FP8 lanes, {lane1, lane0}.
//  Revision  : 1.0 - initial release
// ============================================================================
package lb_pkg;

   localparam int LB_LANES     = 2;
   localparam int FP8_BITS     = 8;
   localparam int LB_WORD_BITS = LB_LANES * FP8_BITS;

   localparam logic [FP8_BITS-1:0] FP8_ZERO = 8'h00;

   typedef logic [LB_WORD_BITS-1:0] lb_word_t;

   // Word with every lane set to FP8 zero.
   function automatic lb_word_t lb_zero_word();
      return {LB_LANES{FP8_ZERO}};
   endfunction

endpackage : lb_pkg
`default_nettype wire

// File: rtl/lb_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module    : lb_sdp_ram
//  Purpose   : Simple dual-port RAM, one write port and one registered read
//              port. Read-first: a read and a write to the same address in
//              the same cycle returns the word held before the write.
//              Neither the array nor the read register is reset, so the
//              storage maps onto block RAM.
//  Ports     : clk        - clock
//              wr_en_i    - write enable
//              wr_addr_i  - write address
//              wr_data_i  - write data
//              rd_en_i    - read enable (read register holds when low)
//              rd_addr_i  - read address
//              rd_data_o  - registered read data
//  Revision  : 1.0 - initial release
// ============================================================================
module lb_sdp_ram #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 16,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Read and write in one process so the old word is sampled before the
   // write lands.
   always_ff @(posedge clk) begin
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule : lb_sdp_ram
`default_nettype wire

// File: rtl/fp8_line_delay_ram.sv
`default_nettype none
// ============================================================================
//  Module    : fp8_line_delay_ram
//  Purpose   : One-line delay for packed FP8 pixel words. Each accepted word
//              is written at the current column while the word stored one
//              line earlier at that column is read out. Output is masked to
//              FP8 zero until a full line of the current frame exists.
//  Ports     : clk        - clock
//              reset      - asynchronous active-high reset
//              sof        - start of frame, qualified by in_valid
//              in_valid   - RAM_in_g carries a pixel
//              RAM_in_g   - {lane1, lane0} pixel to store
//              RAM_out_g  - {lane1, lane0} from one line earlier
//              out_valid  - output qualifier, one cycle after in_valid
//              col_out    - column of the word on RAM_out_g
//              eol_out    - col_out is the last column of the line
//              hist_valid - RAM_out_g carries real history
//  Revision  : 1.0 - initial release
// ============================================================================
module fp8_line_delay_ram
   import lb_pkg::*;
#(
   parameter int line_width = 640,
   parameter int addr_bits  = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sof,
   input  logic                 in_valid,
   input  lb_word_t             RAM_in_g,
   output lb_word_t             RAM_out_g,
   output logic                 out_valid,
   output logic [addr_bits-1:0] col_out,
   output logic                 eol_out,
   output logic                 hist_valid
);

   localparam logic [addr_bits-1:0] LAST_COL = addr_bits'(line_width - 1);
   localparam logic [1:0]           LINE_SAT = 2'd2;

   logic [addr_bits-1:0] col_q, col_d, col_eff;
   logic [1:0]           line_cnt_q, line_cnt_d, line_eff;
   logic                 wrap;

   logic                 out_valid_q;
   logic [addr_bits-1:0] col_out_q;
   logic                 eol_q;
   logic                 hist_q;
   lb_word_t             ram_rd;

   // A qualified sof makes this pixel column 0 of line 0. Because the
   // effective column is then 0, a sof on the last column never wraps and
   // so never bumps the line count.
   always_comb begin
      col_eff    = (sof && in_valid) ? '0   : col_q;
      line_eff   = (sof && in_valid) ? 2'd0 : line_cnt_q;
      wrap       = (col_eff == LAST_COL);
      col_d      = col_q;
      line_cnt_d = line_cnt_q;
      if (in_valid) begin
         col_d      = wrap ? '0 : col_eff + 1'b1;
         line_cnt_d = (wrap && (line_eff != LINE_SAT)) ? line_eff + 2'd1 : line_eff;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q       <= '0;
         line_cnt_q  <= 2'd0;
         out_valid_q <= 1'b0;
         col_out_q   <= '0;
         eol_q       <= 1'b0;
         hist_q      <= 1'b0;
      end else begin
         col_q       <= col_d;
         line_cnt_q  <= line_cnt_d;
         out_valid_q <= in_valid;
         if (in_valid) begin
            col_out_q <= col_eff;
            eol_q     <= wrap;
            hist_q    <= (line_eff != 2'd0);
         end
      end
   end

   lb_sdp_ram #(
      .DEPTH (line_width),
      .WIDTH (LB_WORD_BITS),
      .AW    (addr_bits)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (in_valid),
      .wr_addr_i (col_eff),
      .wr_data_i (RAM_in_g),
      .rd_en_i   (in_valid),
      .rd_addr_i (col_eff),
      .rd_data_o (ram_rd)
   );

   // Masking after the RAM register keeps stale contents (left over from a
   // previous frame or from before reset) off the output. hist_q is cleared
   // by reset, so the output also reads zero out of reset.
   assign RAM_out_g  = hist_q ? ram_rd : lb_zero_word();
   assign out_valid  = out_valid_q;
   assign col_out    = col_out_q;
   assign eol_out    = eol_q;
   assign hist_valid = hist_q;

endmodule : fp8_line_delay_ram
`default_nettype wire

// File: tb/tb_fp8_line_delay_ram.sv
`default_nettype none
// ============================================================================
//  Module    : tb_fp8_line_delay_ram
//  Purpose   : Self-checking bench for fp8_line_delay_ram with a 4-pixel line
//              instance and a 640-pixel line instance.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_fp8_line_delay_ram;

   localparam int LW4 = 4;
   localparam int AB4 = 2;
   localparam int LWB = 640;
   localparam int ABB = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic           sof4, v4;
   logic [15:0]    d4, q4;
   logic           ov4, eol4, hv4;
   logic [AB4-1:0] col4;

   logic           sofb, vb;
   logic [15:0]    db, qb;
   logic           ovb, eolb, hvb;
   logic [ABB-1:0] colb;

   fp8_line_delay_ram #(.line_width(LW4), .addr_bits(AB4)) dut4 (
      .clk(clk), .reset(reset), .sof(sof4), .in_valid(v4), .RAM_in_g(d4),
      .RAM_out_g(q4), .out_valid(ov4), .col_out(col4), .eol_out(eol4),
      .hist_valid(hv4)
   );

   fp8_line_delay_ram #(.line_width(LWB), .addr_bits(ABB)) dutb (
      .clk(clk), .reset(reset), .sof(sofb), .in_valid(vb), .RAM_in_g(db),
      .RAM_out_g(qb), .out_valid(ovb), .col_out(colb), .eol_out(eolb),
      .hist_valid(hvb)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model for the 4-pixel instance: every accepted word of the
   // current frame kept in order; output is the word LW4 samples back.
   // ---------------------------------------------------------------------
   logic [15:0] m_hist[$];
   int          m_n;
   logic [15:0] e_data;
   logic        e_hv, e_eol, e_ov;
   int          e_col;
   int          step;

   function automatic void model_clear();
      m_hist.delete();
      m_n    = 0;
      e_data = 16'h0;
      e_hv   = 1'b0;
      e_eol  = 1'b0;
      e_ov   = 1'b0;
      e_col  = 0;
   endfunction

   task automatic check4(input string tag);
      chk({tag, "_ov"},   step, 32'(ov4),   32'(e_ov));
      chk({tag, "_data"}, step, 32'(q4),    32'(e_data));
      chk({tag, "_hv"},   step, 32'(hv4),   32'(e_hv));
      chk({tag, "_col"},  step, 32'(col4),  32'(e_col));
      chk({tag, "_eol"},  step, 32'(eol4),  32'(e_eol));
   endtask

   // Called at a falling edge; drives one cycle and checks at the next one.
   task automatic cyc4(input string tag, input logic s, input logic v,
                       input logic [15:0] d);
      if (v) begin
         if (s) begin
            m_hist.delete();
            m_n = 0;
         end
         e_col  = m_n % LW4;
         e_eol  = (e_col == LW4 - 1);
         e_hv   = (m_n >= LW4);
         e_data = e_hv ? m_hist[m_n - LW4] : 16'h0000;
         m_hist.push_back(d);
         m_n++;
      end
      e_ov = v;
      sof4 = s;
      v4   = v;
      d4   = d;
      @(negedge clk);
      check4(tag);
      step++;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      sof4 = 1'b0; v4 = 1'b0; d4 = 16'h0;
      sofb = 1'b0; vb = 1'b0; db = 16'h0;
      model_clear();
      @(negedge clk);
      check4(tag);
      step++;
      reset = 1'b0;
   endtask

   typedef struct {
      logic        s;
      logic [15:0] d;
      logic [15:0] ed;
      logic        ehv;
      int          ecol;
      logic        eeol;
   } vec_t;

   vec_t        tbl[12];
   logic [15:0] lines[3][LWB];

   initial begin
      reset = 1'b1;
      sof4 = 1'b0; v4 = 1'b0; d4 = 16'h0;
      sofb = 1'b0; vb = 1'b0; db = 16'h0;
      step = 0;
      model_clear();
      @(negedge clk);
      @(negedge clk);

      // Reset state of both instances.
      check4("rst4");
      chk("rstb_ov",   0, 32'(ovb),  0);
      chk("rstb_data", 0, 32'(qb),   0);
      chk("rstb_hv",   0, 32'(hvb),  0);
      chk("rstb_col",  0, 32'(colb), 0);
      chk("rstb_eol",  0, 32'(eolb), 0);
      reset = 1'b0;

      // 12 back-to-back pixels 0x0101*k, sof on the first.
      for (int k = 1; k <= 12; k++) begin
         tbl[k-1].s    = (k == 1);
         tbl[k-1].d    = 16'(16'h0101 * k);
         tbl[k-1].ehv  = (k > 4);
         tbl[k-1].ed   = (k > 4) ? 16'(16'h0101 * (k - 4)) : 16'h0000;
         tbl[k-1].ecol = (k - 1) % 4;
         tbl[k-1].eeol = ((k - 1) % 4 == 3);
      end
      for (int i = 0; i < 12; i++) begin
         sof4 = tbl[i].s;
         v4   = 1'b1;
         d4   = tbl[i].d;
         @(negedge clk);
         chk("tbl_ov",   i, 32'(ov4),  1);
         chk("tbl_data", i, 32'(q4),   32'(tbl[i].ed));
         chk("tbl_hv",   i, 32'(hv4),  32'(tbl[i].ehv));
         chk("tbl_col",  i, 32'(col4), 32'(tbl[i].ecol));
         chk("tbl_eol",  i, 32'(eol4), 32'(tbl[i].eeol));
      end
      v4 = 1'b0;
      sof4 = 1'b0;

      // Same stream with a gap after every pixel.
      do_reset("rst_gap");
      for (int k = 1; k <= 12; k++) begin
         cyc4("gap", k == 1, 1'b1, 16'(16'h0101 * k));
         cyc4("gap", 1'b0, 1'b0, 16'hDEAD);
      end

      // Reset after pixel 6, resume without sof.
      do_reset("rst_mid_a");
      for (int k = 1; k <= 6; k++) cyc4("pre_rst", k == 1, 1'b1, 16'(16'h0101 * k));
      do_reset("rst_mid_b");
      for (int k = 1; k <= 9; k++) cyc4("post_rst", 1'b0, 1'b1, 16'(16'hAA00 + k));

      // sof at pixel 7 (col 2 of line 1).
      do_reset("rst_sof2");
      for (int k = 1; k <= 16; k++) cyc4("sof_col2", (k == 1) || (k == 7), 1'b1, 16'(16'h0101 * k));

      // sof on the last column of line 0: line count must not advance.
      do_reset("rst_sof3");
      for (int k = 1; k <= 14; k++) cyc4("sof_col3", (k == 1) || (k == 4), 1'b1, 16'(16'h0202 * k));

      // Random traffic with occasional gaps and sof.
      do_reset("rst_rand");
      for (int i = 0; i < 300; i++) begin
         cyc4("rand", ($urandom % 40) == 0, ($urandom % 4) != 0, 16'($urandom));
      end

      // 640-pixel instance: three full lines of random words.
      do_reset("rst_wide");
      for (int l = 0; l < 3; l++)
         for (int c = 0; c < LWB; c++) lines[l][c] = 16'($urandom);
      for (int l = 0; l < 3; l++) begin
         for (int c = 0; c < LWB; c++) begin
            sofb = (l == 0) && (c == 0);
            vb   = 1'b1;
            db   = lines[l][c];
            @(negedge clk);
            chk("wide_ov",   l * LWB + c, 32'(ovb),  1);
            chk("wide_data", l * LWB + c, 32'(qb),   (l == 0) ? 32'h0 : 32'(lines[l-1][c]));
            chk("wide_hv",   l * LWB + c, 32'(hvb),  32'(l != 0));
            chk("wide_col",  l * LWB + c, 32'(colb), 32'(c));
            chk("wide_eol",  l * LWB + c, 32'(eolb), 32'(c == LWB - 1));
         end
      end
      vb = 1'b0;
      sofb = 1'b0;
      @(negedge clk);
      chk("wide_idle_ov",   0, 32'(ovb), 0);
      chk("wide_idle_hold", 0, 32'(qb),  32'(lines[1][LWB-1]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fp8_line_delay_ram
`default_nettype wire
